coefficient_loader: RTL and testbench
=====================================

// Module: coefficient_loader
// PURPOSE
//  Upstream of the FIR filter top. Sequences a bank of NUM_COEFF coefficients held in the
//  AHB-Lite slave register file into the filter, one at a time, using load_coeff/modwait.
//  Drives coefficient_num, which the slave uses to mux the selected coefficient onto fir_coefficient.
//  Clears the slave's new-coefficient request when the whole bank is loaded.
// PARAMETERS
//  NUM_COEFF     4    coefficients per bank; IDXW = $clog2(NUM_COEFF), minimum 1
//  ACK_TIMEOUT   15   max cycles to wait for modwait to rise after a load_coeff pulse
// PORTS
//  clk                  in   1     system clock; all state on rising edge
//  n_reset              in   1     asynchronous, active-low reset
//  new_coefficient_set  in   1     level request from slave: bank ready to load
//  modwait              in   1     filter busy flag from the filter top
//  load_coeff           out  1     one-cycle load strobe to the filter
//  coefficient_num      out  IDXW  index of the coefficient currently presented
//  clear_new_coeff      out  1     one-cycle pulse to slave: clear new_coefficient_set
//  loader_busy          out  1     high in any state other than IDLE/ERR
//  load_err             out  1     handshake timeout; held high while in ERR
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, load_coeff=0, coefficient_num=0, clear_new_coeff=0,
//   loader_busy=0, load_err=0. All outputs are Moore, decoded from registered state/idx.
//  States:
//   IDLE : idx=0. Go to LOAD when new_coefficient_set=1 and modwait=0. Otherwise stay.
//          The request is sampled only here; a request with modwait=1 waits.
//   LOAD : load_coeff=1 for exactly one cycle. Timer cleared. Next state is WAIT_ACK.
//   WAIT_ACK : wait for modwait=1 -> WAIT_DONE. Timer increments each cycle.
//          If the timer reaches ACK_TIMEOUT with modwait still 0 -> ERR.
//   WAIT_DONE : wait for modwait=0. Then, if idx==NUM_COEFF-1 -> CLEAR;
//          otherwise idx<=idx+1 and -> LOAD. There is no timeout here.
//   CLEAR : clear_new_coeff=1 for one cycle, idx<=0, then -> IDLE.
//   ERR  : load_err=1. Leave to IDLE (idx<=0) only when new_coefficient_set=0.
//  coefficient_num=idx. It is stable from LOAD through the end of WAIT_DONE, so the slave
//   mux output is held while the filter copies it.
//  Latency: from request to the first load_coeff is 1 cycle (IDLE->LOAD).
//   Per coefficient: 1 (LOAD) + ack cycles + busy cycles + 1 transition.
//  Boundaries:
//   - new_coefficient_set drops mid-sequence: ignored. The bank always completes, so the
//     filter never holds a partial set. CLEAR still pulses.
//   - new_coefficient_set still high in the cycle after CLEAR (slave clear lag): IDLE needs
//     it high with modwait=0. The slave must drop it in the cycle after clear_new_coeff.
//     The bench checks that no second LOAD occurs in that case.
//   - modwait already 1 in the LOAD cycle: WAIT_ACK exits on the next cycle (level check).
//   - idx wrap: idx never exceeds NUM_COEFF-1. It resets to 0 in CLEAR, ERR exit and reset.
//   - Reset mid-sequence: immediate return to reset values. No clear pulse is issued.
//     The slave request stays set, so the load restarts from idx 0 after reset.
// STRUCTURE
//  Shared package fir_pkg:
//   - typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE, CLEAR, ERR} loader_state_t
//   - localparam NUM_COEFF_DEFAULT = 4
//  One sub-module, ack_timer: a clearable up-counter with terminal flag at ACK_TIMEOUT.
//   Cleared in LOAD, enabled in WAIT_ACK.
//  The top contains the state register, next-state logic and idx register.
// TESTING
//  1 Reset, then request=1 with modwait=0 -> load_coeff on cycle 1. The filter model raises
//    modwait for 3 cycles per load. Expect coefficient_num 0,1,2,3, four load pulses,
//    then one clear_new_coeff pulse.
//  2 Request=1 with modwait=1 held for 5 cycles -> no load_coeff.
//    First load_coeff 1 cycle after modwait falls.
//  3 Filter model never raises modwait -> load_err=1 after 1+15 cycles in WAIT_ACK.
//    Drop the request -> IDLE, load_err=0, coefficient_num=0.
//  4 Drop the request after the second load -> the sequence completes all 4 loads
//    and clear_new_coeff still pulses.
//  5 Assert n_reset=0 during WAIT_DONE of idx 2 -> all outputs return to reset values
//    immediately. After release with the request still high, loading restarts at idx 0.
//  6 The slave keeps the request high one extra cycle after clear -> exactly 4 loads total,
//    with no restart.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR-filter types: coefficient loader state encoding and bank defaults.
package fir_pkg;

    localparam int unsigned NUM_COEFF_DEFAULT   = 4;
    localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        CLEAR     = 3'd4,
        ERR       = 3'd5
    } loader_state_t;

endpackage

// File: rtl/coefficient_loader_ack_timer.sv
// Clearable saturating up-counter that flags the cycle in which the handshake wait
// would reach ACK_TIMEOUT.
module ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c_o
);

    localparam int unsigned CNTW = $clog2(ACK_TIMEOUT + 1);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNTW'(ACK_TIMEOUT))) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High in the waiting cycle whose increment brings the count to ACK_TIMEOUT.
    assign expire_c_o = (count_q == CNTW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/coefficient_loader.sv
// Steps a bank of NUM_COEFF coefficients from the slave register file into the FIR
// filter using the load_coeff / modwait handshake, then clears the slave request.
module coefficient_loader
    import fir_pkg::*;
#(
    parameter  int unsigned NUM_COEFF   = NUM_COEFF_DEFAULT,
    parameter  int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
    localparam int unsigned IDXW        = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            new_coefficient_set,
    input  logic            modwait,
    output logic            load_coeff,
    output logic [IDXW-1:0] coefficient_num,
    output logic            clear_new_coeff,
    output logic            loader_busy,
    output logic            load_err
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_COEFF - 1);

    loader_state_t   state_q;
    loader_state_t   state_d;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;

    logic load_coeff_q;
    logic clear_new_coeff_q;
    logic loader_busy_q;
    logic load_err_q;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expire_c;

    assign tmr_clear  = (state_q == LOAD);
    assign tmr_enable = (state_q == WAIT_ACK);

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear_i    (tmr_clear),
        .enable_i   (tmr_enable),
        .expire_c_o (tmr_expire_c)
    );

    // Next-state and index sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (new_coefficient_set && !modwait) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (modwait) begin
                    state_d = WAIT_DONE;
                end else if (tmr_expire_c) begin
                    state_d = ERR;
                end
            end
            WAIT_DONE: begin
                if (!modwait) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = CLEAR;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = LOAD;
                    end
                end
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                if (!new_coefficient_set) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            load_coeff_q      <= 1'b0;
            clear_new_coeff_q <= 1'b0;
            loader_busy_q     <= 1'b0;
            load_err_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            load_coeff_q      <= (state_d == LOAD);
            clear_new_coeff_q <= (state_d == CLEAR);
            loader_busy_q     <= (state_d != IDLE) && (state_d != ERR);
            load_err_q        <= (state_d == ERR);
        end
    end

    assign load_coeff      = load_coeff_q;
    assign coefficient_num = idx_q;
    assign clear_new_coeff = clear_new_coeff_q;
    assign loader_busy     = loader_busy_q;
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_coefficient_loader.sv
// Directed bench for coefficient_loader with a small filter model answering load_coeff.
module tb_coefficient_loader;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       new_coefficient_set;
    logic       modwait;
    logic       load_coeff;
    logic [1:0] coefficient_num;
    logic       clear_new_coeff;
    logic       loader_busy;
    logic       load_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic force_mw   = 1'b0;
    int   busy       = 0;
    int   loads_total  = 0;
    int   clears_total = 0;
    int   fm_limit   = 1000000;
    int   cyc        = 0;
    int   rec_num [64];
    int   rec_cyc [64];

    coefficient_loader #(
        .NUM_COEFF   (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .new_coefficient_set (new_coefficient_set),
        .modwait             (modwait),
        .load_coeff          (load_coeff),
        .coefficient_num     (coefficient_num),
        .clear_new_coeff     (clear_new_coeff),
        .loader_busy         (loader_busy),
        .load_err            (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: holds modwait for 3 cycles after each acknowledged load strobe.
    always @(negedge clk) begin
        if (load_coeff) begin
            if (loads_total < 64) begin
                rec_num[loads_total] = int'(coefficient_num);
                rec_cyc[loads_total] = cyc;
            end
            loads_total = loads_total + 1;
            busy = (loads_total <= fm_limit) ? 3 : 0;
        end else if (busy > 0) begin
            busy = busy - 1;
        end
        if (clear_new_coeff) clears_total = clears_total + 1;
    end

    assign modwait = force_mw | (busy != 0);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_clear(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (clear_new_coeff) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_loads(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (loads_total >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        new_coefficient_set = 1'b0;
        step();
        step();
        n_checks++;
        if ({load_coeff, clear_new_coeff, loader_busy, load_err} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {load_coeff, clear_new_coeff, loader_busy, load_err});
        else n_pass++;
        n_checks++;
        if (coefficient_num !== 2'd0)
            $display("FAIL reset_num: got %0d want 0", coefficient_num);
        else n_pass++;
        n_reset = 1'b1;
        step();
    endtask

    task automatic test_full_bank();
        int base = loads_total;
        int cb   = clears_total;
        bit ok;
        new_coefficient_set = 1'b1;
        step();
        n_checks++;
        if (load_coeff !== 1'b1 || coefficient_num !== 2'd0)
            $display("FAIL full_first_load: got load=%b num=%0d want load=1 num=0",
                     load_coeff, coefficient_num);
        else n_pass++;
        wait_clear(ok);
        new_coefficient_set = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL full_clear_seen: got none want clear pulse");
        else n_pass++;
        step();
        step();
        n_checks++;
        if (loads_total - base !== 4)
            $display("FAIL full_load_count: got %0d want 4", loads_total - base);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rec_num[base + i] !== i)
                $display("FAIL full_num_%0d: got %0d want %0d", i, rec_num[base + i], i);
            else n_pass++;
        end
        n_checks++;
        if (rec_cyc[base + 3] - rec_cyc[base + 2] !== 4)
            $display("FAIL full_load_spacing: got %0d want 4",
                     rec_cyc[base + 3] - rec_cyc[base + 2]);
        else n_pass++;
        n_checks++;
        if (clears_total - cb !== 1)
            $display("FAIL full_clear_count: got %0d want 1", clears_total - cb);
        else n_pass++;
        n_checks++;
        if (loader_busy !== 1'b0)
            $display("FAIL full_idle_busy: got %b want 0", loader_busy);
        else n_pass++;
    endtask

    task automatic test_modwait_hold();
        int base = loads_total;
        bit ok;
        force_mw = 1'b1;
        new_coefficient_set = 1'b1;
        repeat (5) step();
        n_checks++;
        if (loads_total - base !== 0 || loader_busy !== 1'b0)
            $display("FAIL hold_no_load: got loads=%0d busy=%b want loads=0 busy=0",
                     loads_total - base, loader_busy);
        else n_pass++;
        force_mw = 1'b0;
        step();
        n_checks++;
        if (load_coeff !== 1'b1)
            $display("FAIL hold_load_after_release: got %b want 1", load_coeff);
        else n_pass++;
        wait_clear(ok);
        new_coefficient_set = 1'b0;
        step();
        n_checks++;
        if (!ok || loads_total - base !== 4)
            $display("FAIL hold_complete: got ok=%b loads=%0d want ok=1 loads=4",
                     ok, loads_total - base);
        else n_pass++;
    endtask

    task automatic test_ack_timeout();
        int base = loads_total;
        bit ok;
        fm_limit = loads_total + 1;
        new_coefficient_set = 1'b1;
        wait_loads(base + 2, ok);
        n_checks++;
        if (!ok || coefficient_num !== 2'd1)
            $display("FAIL to_second_load: got ok=%b num=%0d want ok=1 num=1",
                     ok, coefficient_num);
        else n_pass++;
        repeat (15) step();
        n_checks++;
        if (load_err !== 1'b0 || loader_busy !== 1'b1)
            $display("FAIL to_before_err: got err=%b busy=%b want err=0 busy=1",
                     load_err, loader_busy);
        else n_pass++;
        step();
        n_checks++;
        if (load_err !== 1'b1 || loader_busy !== 1'b0)
            $display("FAIL to_err_set: got err=%b busy=%b want err=1 busy=0",
                     load_err, loader_busy);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (load_err !== 1'b1 || load_coeff !== 1'b0)
            $display("FAIL to_err_held: got err=%b load=%b want err=1 load=0",
                     load_err, load_coeff);
        else n_pass++;
        new_coefficient_set = 1'b0;
        step();
        n_checks++;
        if (load_err !== 1'b0 || coefficient_num !== 2'd0 || loader_busy !== 1'b0)
            $display("FAIL to_err_exit: got err=%b num=%0d busy=%b want err=0 num=0 busy=0",
                     load_err, coefficient_num, loader_busy);
        else n_pass++;
        fm_limit = 1000000;
        step();
    endtask

    task automatic test_req_drop();
        int base = loads_total;
        int cb   = clears_total;
        bit ok;
        new_coefficient_set = 1'b1;
        wait_loads(base + 2, ok);
        new_coefficient_set = 1'b0;
        wait_clear(ok);
        step();
        n_checks++;
        if (!ok || loads_total - base !== 4 || clears_total - cb !== 1)
            $display("FAIL drop_complete: got ok=%b loads=%0d clears=%0d want ok=1 loads=4 clears=1",
                     ok, loads_total - base, clears_total - cb);
        else n_pass++;
        n_checks++;
        if (rec_num[base + 3] !== 3)
            $display("FAIL drop_last_num: got %0d want 3", rec_num[base + 3]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base = loads_total;
        int cb   = clears_total;
        int base2;
        bit ok;
        new_coefficient_set = 1'b1;
        wait_loads(base + 3, ok);
        step();
        step();
        n_checks++;
        if (!ok || coefficient_num !== 2'd2 || loader_busy !== 1'b1)
            $display("FAIL rst_pre: got ok=%b num=%0d busy=%b want ok=1 num=2 busy=1",
                     ok, coefficient_num, loader_busy);
        else n_pass++;
        n_reset = 1'b0;
        #1;
        n_checks++;
        if ({load_coeff, clear_new_coeff, loader_busy, load_err, coefficient_num} !== 6'd0)
            $display("FAIL rst_immediate: got %b want 000000",
                     {load_coeff, clear_new_coeff, loader_busy, load_err, coefficient_num});
        else n_pass++;
        step();
        step();
        n_reset = 1'b1;
        base2 = loads_total;
        step();
        n_checks++;
        if (load_coeff !== 1'b1 || coefficient_num !== 2'd0 || clears_total !== cb)
            $display("FAIL rst_restart: got load=%b num=%0d clears=%0d want load=1 num=0 clears=%0d",
                     load_coeff, coefficient_num, clears_total, cb);
        else n_pass++;
        wait_clear(ok);
        new_coefficient_set = 1'b0;
        step();
        n_checks++;
        if (!ok || loads_total - base2 !== 4 || clears_total - cb !== 1)
            $display("FAIL rst_complete: got ok=%b loads=%0d clears=%0d want ok=1 loads=4 clears=1",
                     ok, loads_total - base2, clears_total - cb);
        else n_pass++;
    endtask

    task automatic test_clear_lag();
        int base = loads_total;
        int cb   = clears_total;
        bit ok;
        new_coefficient_set = 1'b1;
        wait_clear(ok);
        step();
        new_coefficient_set = 1'b0;
        repeat (8) step();
        n_checks++;
        if (!ok || loads_total - base !== 4)
            $display("FAIL lag_load_count: got ok=%b loads=%0d want ok=1 loads=4",
                     ok, loads_total - base);
        else n_pass++;
        n_checks++;
        if (clears_total - cb !== 1 || loader_busy !== 1'b0)
            $display("FAIL lag_idle: got clears=%0d busy=%b want clears=1 busy=0",
                     clears_total - cb, loader_busy);
        else n_pass++;
    endtask

    initial begin
        n_reset = 1'b0;
        new_coefficient_set = 1'b0;
        test_reset();
        test_full_bank();
        test_modwait_hold();
        test_ack_timeout();
        test_req_drop();
        test_reset_mid();
        test_clear_lag();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
